dma_dev_port: RTL and testbench
===============================

# dma_dev_port

Parametrised device-side endpoint for the DMA controller, and the next generation of the fixed-width device model. It latches a transfer descriptor (word count, start address, direction), requests the DMA, and moves data over the `dma_ack`/`dev_ack` handshake. It buffers data in an internal FIFO and applies flow control in both directions. It adds end-of-transfer checking and a watchdog timeout, and sits between host logic and one DMA controller channel.

## Interface
- `DATA`, default 8: data word width.
- `ADD`, default 7: address width.
- `WORD`, default 5: word-count width is WORD+1.
- `FIFO_DEPTH`, default 8: buffer entries, power of 2, ≥2.
- `TIMEOUT`, default 64: cycles without progress before error; 0 disables the watchdog.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin transfer; sampled only in IDLE.
- `in_num_words`  in  WORD+1  words to transfer.
- `in_start_address`  in  ADD  memory start address.
- `in_rd_wr`  in  1  1 = DMA reads memory into device, 0 = device writes to memory.
- `host_wr_en`, `host_wr_data`  in  1 / DATA  push into FIFO; honoured only when `in_rd_wr` latched 0 or in IDLE, and FIFO not full.
- `host_rd_en`  in  1  pop FIFO head; ignored when empty.
- `host_rd_data`  out  DATA  FIFO head (show-ahead).
- `fifo_full`, `fifo_empty`  out  1  FIFO flags.
- `num_words`, `start_address`, `rd_wr`  out  WORD+1 / ADD / 1  latched descriptor to DMA.
- `rqst`  out  1  DMA request.
- `dma_ack`  in  1  DMA grant / beat valid.
- `dma_end_flag`  in  1  DMA finished transfer.
- `dev_in`  in  DATA  read data from DMA.
- `dev_out`  out  DATA  write data to DMA.
- `dev_ack`  out  1  device ready for a beat.
- `dev_ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `error`  out  1  sticky error flag; cleared on an accepted `start`.

## Operation
- States: IDLE, LATCH, REQ, XFER, DRAIN, DONE, ERR.
- IDLE: when `start`=1, go to LATCH. LATCH loads the descriptor registers and clears the beat counter `cnt`.
- LATCH: if `num_words`=0, go to DONE (no `rqst`); otherwise go to REQ.
- REQ: `rqst`=1. When `dma_ack`=1, go to XFER.
- XFER, read (`rd_wr`=1): `dev_ack` = !fifo_full && cnt<num_words. A beat is `dma_ack`&&`dev_ack` at the edge; it pushes `dev_in` and increments `cnt`.
- XFER, write (`rd_wr`=0): `dev_ack` = !fifo_empty && cnt<num_words, and `dev_out` = FIFO head. A beat pops the FIFO and increments `cnt`.
- Outside a write XFER, `dev_out`=0.
- When `cnt` reaches `num_words`, go to DRAIN.
- DRAIN: when `dma_end_flag`=1, go to DONE.
- DONE: `dev_ready`=1 for one cycle, then go to IDLE.
- `dma_end_flag`=1 in XFER with cnt<num_words: go to ERR.
- Watchdog: `wd` counts cycles in REQ/XFER/DRAIN, clearing on each beat and on every state change. `wd`==TIMEOUT goes to ERR.
- ERR: sets `error`, flushes the FIFO, goes to IDLE after one cycle.
- Host pops in read mode may run concurrently with DMA pushes. A simultaneous push and pop when full or empty is resolved per the FIFO rules below.

## Timing
- Reset values: state IDLE, all outputs 0 except `fifo_empty`=1; FIFO emptied; descriptor registers 0.
- `start` at edge N: LATCH during cycle N+1. `rqst` is first high in cycle N+2.
- `rqst`, `dev_ready`, and `busy` are Moore outputs.
- `dev_ack` is combinational from registered state only, never from `dma_ack`.
- Throughput: one beat per cycle when unthrottled.
- `dev_ready` is high exactly 2 cycles after the edge that accepts the last beat, with `dma_end_flag` already high (LATCH→…→DRAIN→DONE).
- `cnt` is WORD+1 bits and never exceeds `num_words`.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap.
- Push and pop together when full: the pop happens, and the push is allowed.
- Push and pop together when empty: the push happens, and the pop is ignored.
- Reset mid-transfer: immediate return to IDLE, `rqst`/`dev_ack` drop asynchronously, FIFO contents lost.

## Structure
- Shared package `dma_pkg`: state encoding (`dma_dev_state_t`), the direction constants DIR_RD=1 and DIR_WR=0, and default parameter constants.
- Sub-module `sync_fifo` (DATA, FIFO_DEPTH): show-ahead, with `full`/`empty` flags and a synchronous flush. The FSM, counters, and descriptor registers stay in the top level.

## Test plan
- Read 4 words, `dev_in`=0x11,0x22,0x33,0x44, `dma_ack` held, `dma_end_flag` after the last beat → FIFO holds the 4 values in order, one `dev_ready` pulse, `error`=0.
- Preload 3 words 0xA0,0xA1,0xA2, write `num_words`=3 → `dev_out` presents 0xA0,0xA1,0xA2 on 3 consecutive beats, FIFO empty, `dev_ready` after the end flag.
- Read 10 words with FIFO_DEPTH=8 and no host pops → `dev_ack` drops after 8 beats. After 2 host pops, `dev_ack` rises and the remaining 2 beats complete.
- `dma_end_flag` asserted after 2 of 5 read beats → ERR, `error`=1, FIFO flushed, back in IDLE; the next `start` clears `error`.
- `rqst` with no `dma_ack` for 64 cycles → `error`=1, `rqst` deasserts.
- `reset` pulsed mid-XFER → `rqst`=`dev_ack`=0 immediately, `fifo_empty`=1. Separately, a `start` with `num_words`=0 gives `dev_ready` with no `rqst`.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA device-side endpoint: state encoding,
// transfer direction constants and default parameter values.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_REQ,
        ST_XFER,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } dma_dev_state_t;

    localparam logic DIR_RD = 1'b1;
    localparam logic DIR_WR = 1'b0;

    localparam int DEF_DATA       = 8;
    localparam int DEF_ADD        = 7;
    localparam int DEF_WORD       = 5;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_TIMEOUT    = 64;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags and a synchronous flush.
// A pop while full frees the slot that a simultaneous push then fills.
module sync_fifo #(
    parameter int DATA       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [DATA-1:0] din_i,
    input  logic            pop_i,
    output logic [DATA-1:0] dout_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA-1:0] mem_q [FIFO_DEPTH];
    logic            do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop on an empty FIFO is dropped even if a push lands the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/dma_dev_port.sv
// Device-side DMA endpoint: latches a descriptor, requests the DMA, moves
// beats through a local FIFO and checks for early end / stalled transfers.
module dma_dev_port
    import dma_pkg::*;
#(
    parameter int DATA       = DEF_DATA,
    parameter int ADD        = DEF_ADD,
    parameter int WORD       = DEF_WORD,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [WORD:0]   in_num_words,
    input  logic [ADD-1:0]  in_start_address,
    input  logic            in_rd_wr,
    input  logic            host_wr_en,
    input  logic [DATA-1:0] host_wr_data,
    input  logic            host_rd_en,
    output logic [DATA-1:0] host_rd_data,
    output logic            fifo_full,
    output logic            fifo_empty,
    output logic [WORD:0]   num_words,
    output logic [ADD-1:0]  start_address,
    output logic            rd_wr,
    output logic            rqst,
    input  logic            dma_ack,
    input  logic            dma_end_flag,
    input  logic [DATA-1:0] dev_in,
    output logic [DATA-1:0] dev_out,
    output logic            dev_ack,
    output logic            dev_ready,
    output logic            busy,
    output logic            error
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WORD:0] CNT_ONE = 1;
    localparam logic [WD_W-1:0] WD_ONE = 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    dma_dev_state_t  state_q, state_d;
    logic [WORD:0]   num_words_q, cnt_q, cnt_d;
    logic [ADD-1:0]  addr_q;
    logic            rd_wr_q, error_q, error_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic            accept, xfer, beat, wd_active;
    logic            fifo_push, fifo_pop, fifo_flush;
    logic [DATA-1:0] fifo_din, fifo_dout;

    assign accept    = (state_q == ST_IDLE) && start;
    assign xfer      = (state_q == ST_XFER);
    assign wd_active = (state_q == ST_REQ) || xfer || (state_q == ST_DRAIN);

    // Ready depends only on registered state so the DMA can't form a loop.
    assign dev_ack = xfer && (cnt_q < num_words_q) &&
                     ((rd_wr_q == DIR_RD) ? !fifo_full : !fifo_empty);
    assign beat    = dev_ack && dma_ack;
    assign cnt_d   = accept ? '0 : (beat ? cnt_q + CNT_ONE : cnt_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_LATCH;
            ST_LATCH: state_d = (num_words_q == '0) ? ST_DONE : ST_REQ;
            ST_REQ:   if (dma_ack) state_d = ST_XFER;
            ST_XFER: begin
                // Count includes a beat landing this cycle, so an end flag
                // that arrives with the final beat is not treated as early.
                if (dma_end_flag && (cnt_d < num_words_q)) state_d = ST_ERR;
                else if (cnt_q == num_words_q)             state_d = ST_DRAIN;
            end
            ST_DRAIN: if (dma_end_flag) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if ((TIMEOUT != 0) && wd_active && (wd_q == WD_MAX)) state_d = ST_ERR;
    end

    always_comb begin
        wd_d = '0;
        if (wd_active && (state_d == state_q) && !beat) wd_d = wd_q + WD_ONE;
        error_d = error_q;
        if (accept)                  error_d = 1'b0;
        else if (state_d == ST_ERR)  error_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wd_q        <= '0;
            error_q     <= 1'b0;
            num_words_q <= '0;
            addr_q      <= '0;
            rd_wr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            error_q <= error_d;
            // Loaded on the accepting edge so LATCH already sees the descriptor.
            if (accept) begin
                num_words_q <= in_num_words;
                addr_q      <= in_start_address;
                rd_wr_q     <= in_rd_wr;
            end
        end
    end

    assign fifo_flush = (state_q == ST_ERR);
    assign fifo_push  = (beat && rd_wr_q == DIR_RD) ||
                        (host_wr_en && ((state_q == ST_IDLE) || (rd_wr_q == DIR_WR)));
    assign fifo_din   = (beat && rd_wr_q == DIR_RD) ? dev_in : host_wr_data;
    assign fifo_pop   = (beat && rd_wr_q == DIR_WR) || host_rd_en;

    sync_fifo #(
        .DATA       (DATA),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign host_rd_data  = fifo_dout;
    assign dev_out       = (xfer && rd_wr_q == DIR_WR) ? fifo_dout : '0;
    assign num_words     = num_words_q;
    assign start_address = addr_q;
    assign rd_wr         = rd_wr_q;
    assign rqst          = (state_q == ST_REQ);
    assign dev_ready     = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);
    assign error         = error_q;

endmodule

// File: tb/tb_dma_dev_port.sv
// Directed bench for dma_dev_port: data expected from the FIFO or on dev_out
// is queued when driven and compared when the DUT presents it.
module tb_dma_dev_port;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] in_num_words = '0;
    logic [6:0] in_start_address = '0;
    logic       in_rd_wr = 1'b0;
    logic       host_wr_en = 1'b0;
    logic [7:0] host_wr_data = '0;
    logic       host_rd_en = 1'b0;
    logic [7:0] host_rd_data;
    logic       fifo_full, fifo_empty;
    logic [5:0] num_words;
    logic [6:0] start_address;
    logic       rd_wr, rqst;
    logic       dma_ack = 1'b0;
    logic       dma_end_flag = 1'b0;
    logic [7:0] dev_in = '0;
    logic [7:0] dev_out;
    logic       dev_ack, dev_ready, busy, error;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    dma_dev_port dut (
        .clk(clk), .reset(reset), .start(start),
        .in_num_words(in_num_words), .in_start_address(in_start_address),
        .in_rd_wr(in_rd_wr), .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
        .host_rd_en(host_rd_en), .host_rd_data(host_rd_data),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .num_words(num_words), .start_address(start_address), .rd_wr(rd_wr),
        .rqst(rqst), .dma_ack(dma_ack), .dma_end_flag(dma_end_flag),
        .dev_in(dev_in), .dev_out(dev_out), .dev_ack(dev_ack),
        .dev_ready(dev_ready), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start for one edge; returns in LATCH.
    task automatic go(input logic [5:0] n, input logic [6:0] a, input logic dir);
        in_num_words = n; in_start_address = a; in_rd_wr = dir; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        e = exp_q.pop_front();
        chk(tag, host_rd_data, e);
        host_rd_en = 1'b1;
        tick();
        host_rd_en = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_rqst", rqst, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_error", error, 0);
        chk("rst_dev_out", dev_out, 0);
        chk("rst_num_words", num_words, 0);

        // Read 4 words
        go(6'd4, 7'h15, 1'b1);
        chk("rd4_latch_busy", busy, 1);
        chk("rd4_latch_rqst", rqst, 0);
        chk("rd4_num_words", num_words, 4);
        chk("rd4_addr", start_address, 7'h15);
        chk("rd4_dir", rd_wr, 1);
        tick();
        chk("rd4_rqst", rqst, 1);
        chk("rd4_req_devack", dev_ack, 0);
        dma_ack = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            dev_in = 8'(8'h11 * (i + 1));
            exp_q.push_back(dev_in);
            chk("rd4_devack", dev_ack, 1);
            tick();
        end
        dma_ack = 1'b0; dma_end_flag = 1'b1;
        chk("rd4_devack_done", dev_ack, 0);
        tick();
        chk("rd4_ready_early", dev_ready, 0);
        tick();
        chk("rd4_ready", dev_ready, 1);
        dma_end_flag = 1'b0;
        tick();
        chk("rd4_ready_pulse", dev_ready, 0);
        chk("rd4_idle", busy, 0);
        chk("rd4_error", error, 0);
        for (int i = 0; i < 4; i++) pop_chk("rd4_data");
        chk("rd4_empty", fifo_empty, 1);

        // Preload and write 3 words
        for (int i = 0; i < 3; i++) begin
            host_wr_en = 1'b1; host_wr_data = 8'(8'hA0 + i);
            exp_q.push_back(host_wr_data);
            tick();
        end
        host_wr_en = 1'b0;
        go(6'd3, 7'h40, 1'b0);
        tick();
        dma_ack = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            chk("wr3_devack", dev_ack, 1);
            chk("wr3_dev_out", dev_out, e);
            tick();
        end
        dma_ack = 1'b0; dma_end_flag = 1'b1;
        chk("wr3_empty", fifo_empty, 1);
        chk("wr3_devack_done", dev_ack, 0);
        tick(); tick();
        chk("wr3_ready", dev_ready, 1);
        dma_end_flag = 1'b0;
        tick();
        chk("wr3_dev_out_idle", dev_out, 0);

        // Read 10 into depth-8 FIFO: back-pressure then resume
        go(6'd10, 7'h00, 1'b1);
        tick();
        dma_ack = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            dev_in = 8'(8'h30 + i);
            exp_q.push_back(dev_in);
            tick();
        end
        chk("rd10_full", fifo_full, 1);
        chk("rd10_stall", dev_ack, 0);
        tick(); tick();
        chk("rd10_stall_hold", dev_ack, 0);
        dma_ack = 1'b0;
        pop_chk("rd10_pop");
        pop_chk("rd10_pop");
        chk("rd10_resume", dev_ack, 1);
        dma_ack = 1'b1;
        for (int i = 8; i < 10; i++) begin
            dev_in = 8'(8'h30 + i);
            exp_q.push_back(dev_in);
            tick();
        end
        dma_ack = 1'b0; dma_end_flag = 1'b1;
        chk("rd10_done_devack", dev_ack, 0);
        chk("rd10_full2", fifo_full, 1);
        tick(); tick();
        chk("rd10_ready", dev_ready, 1);
        dma_end_flag = 1'b0;
        tick();

        // Push and pop together while full, then while empty
        e = exp_q.pop_front();
        chk("full_pp_head", host_rd_data, e);
        host_wr_en = 1'b1; host_wr_data = 8'h55; host_rd_en = 1'b1;
        exp_q.push_back(8'h55);
        tick();
        host_wr_en = 1'b0; host_rd_en = 1'b0;
        chk("full_pp_full", fifo_full, 1);
        for (int i = 0; i < 8; i++) pop_chk("full_pp_data");
        chk("drain_empty", fifo_empty, 1);
        host_wr_en = 1'b1; host_wr_data = 8'h66; host_rd_en = 1'b1;
        tick();
        host_wr_en = 1'b0; host_rd_en = 1'b0;
        chk("empty_pp_notempty", fifo_empty, 0);
        chk("empty_pp_data", host_rd_data, 8'h66);
        host_rd_en = 1'b1;
        tick();
        host_rd_en = 1'b0;

        // Early end flag after 2 of 5
        go(6'd5, 7'h10, 1'b1);
        tick();
        dma_ack = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            dev_in = 8'(8'hE0 + i);
            tick();
        end
        dma_ack = 1'b0; dma_end_flag = 1'b1;
        tick();
        dma_end_flag = 1'b0;
        chk("early_error", error, 1);
        tick();
        chk("early_idle", busy, 0);
        chk("early_flushed", fifo_empty, 1);
        chk("early_sticky", error, 1);

        // Zero-word transfer, also clears the error
        go(6'd0, 7'h01, 1'b1);
        chk("zero_err_clr", error, 0);
        chk("zero_latch_rqst", rqst, 0);
        tick();
        chk("zero_ready", dev_ready, 1);
        chk("zero_rqst", rqst, 0);
        tick();
        chk("zero_idle", busy, 0);

        // Watchdog in REQ
        go(6'd3, 7'h02, 1'b1);
        tick();
        repeat (60) tick();
        chk("wd_still_req", rqst, 1);
        for (int i = 0; i < 20 && rqst; i++) tick();
        chk("wd_rqst_drop", rqst, 0);
        chk("wd_error", error, 1);
        tick();
        chk("wd_idle", busy, 0);

        // Asynchronous reset mid-XFER
        go(6'd4, 7'h03, 1'b1);
        tick();
        dma_ack = 1'b1;
        tick();
        dev_in = 8'h77;
        tick();
        chk("rstx_devack_pre", dev_ack, 1);
        chk("rstx_notempty", fifo_empty, 0);
        #2 reset = 1'b1;
        #1;
        chk("rstx_devack", dev_ack, 0);
        chk("rstx_rqst", rqst, 0);
        chk("rstx_empty", fifo_empty, 1);
        chk("rstx_busy", busy, 0);
        dma_ack = 1'b0;
        #2 reset = 1'b0;
        tick();
        chk("rstx_error", error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
